// File: rtl/bus_serializer.sv
// Single-wire frame transmitter: start bit, WIDTH data bits LSB first, even parity, stop bit.
// Each symbol is held for BIT_CYCLES clocks; one word is accepted per frame through valid/ready.
module bus_serializer #(
    parameter int WIDTH      = 41,
    parameter int BIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [BW-1:0]    bitcnt, bitcnt_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic             par, par_nxt;
    logic             ser_nxt, done_nxt;
    logic             tick, accept;

    assign tick   = (cnt == CNT_LAST);
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bitcnt  <= '0;
            sr      <= '0;
            par     <= 1'b0;
            ser_out <= 1'b1;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bitcnt  <= bitcnt_nxt;
            sr      <= sr_nxt;
            par     <= par_nxt;
            ser_out <= ser_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = START;
            START:   if (tick) state_nxt = DATA;
            DATA:    if (tick && bitcnt == BIT_LAST) state_nxt = PARITY;
            PARITY:  if (tick) state_nxt = STOP;
            STOP:    if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ser_out is registered, so each symbol's value is loaded on the edge that enters it.
    always_comb begin
        in_ready   = (state == IDLE) && !reset;
        busy       = (state != IDLE);
        cnt_nxt    = '0;
        bitcnt_nxt = bitcnt;
        sr_nxt     = sr;
        par_nxt    = par;
        ser_nxt    = ser_out;
        done_nxt   = 1'b0;
        if (state != IDLE)
            cnt_nxt = tick ? '0 : cnt + CW'(1);
        case (state)
            IDLE: begin
                ser_nxt = 1'b1;
                if (accept) begin
                    sr_nxt     = in_data;
                    par_nxt    = ^in_data;
                    bitcnt_nxt = '0;
                    ser_nxt    = 1'b0;
                end
            end
            START: if (tick) ser_nxt = sr[0];
            DATA: begin
                if (tick) begin
                    sr_nxt = sr >> 1;
                    if (bitcnt == BIT_LAST) begin
                        ser_nxt    = par;
                        bitcnt_nxt = '0;
                    end else begin
                        ser_nxt    = sr_nxt[0];
                        bitcnt_nxt = bitcnt + BW'(1);
                    end
                end
            end
            PARITY: if (tick) ser_nxt = 1'b1;
            STOP: begin
                if (tick) begin
                    ser_nxt  = 1'b1;
                    done_nxt = 1'b1;
                end
            end
            default: ser_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_bus_serializer.sv
// Directed bench for bus_serializer: default 41-bit/4-cycle instance plus an 8-bit/1-cycle instance.
module tb_bus_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [40:0] in_data;
    logic        in_ready, ser_out, busy, done;
    logic        in_valid8;
    logic [7:0]  in_data8;
    logic        in_ready8, ser_out8, busy8, done8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_serializer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ser_out(ser_out), .busy(busy), .done(done)
    );

    bus_serializer #(.WIDTH(8), .BIT_CYCLES(1)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_data(in_data8),
        .in_ready(in_ready8), .ser_out(ser_out8), .busy(busy8), .done(done8)
    );

    // Handshake on the next edge; returns #1 into cycle t+1.
    task automatic start_frame(input logic [40:0] d);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Checks cycles t+1..t+176 and the done cycle t+177; ends at the done-cycle negedge.
    task automatic check_frame(input logic [40:0] d, input logic p, input string name);
        int   s, bad_ser, bad_bsy, first_k;
        logic e, got_s, exp_s;
        bad_ser = 0; bad_bsy = 0; first_k = 0; got_s = 1'b0; exp_s = 1'b0;
        for (int k = 1; k <= 176; k++) begin
            @(negedge clk);
            s = (k - 1) / 4;
            if (s == 0)       e = 1'b0;
            else if (s <= 41) e = d[s-1];
            else if (s == 42) e = p;
            else              e = 1'b1;
            if (ser_out !== e) begin
                if (bad_ser == 0) begin first_k = k; got_s = ser_out; exp_s = e; end
                bad_ser++;
            end
            if (busy !== 1'b1 || done !== 1'b0) bad_bsy++;
        end
        n_cmp++;
        if (bad_ser != 0) begin
            n_err++;
            $display("FAIL %s ser_out: %0d bad cycles, first at t+%0d got %b expected %b",
                     name, bad_ser, first_k, got_s, exp_s);
        end
        n_cmp++;
        if (bad_bsy != 0) begin
            n_err++;
            $display("FAIL %s busy/done during frame: %0d bad cycles, expected busy=1 done=0", name, bad_bsy);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, busy, ser_out, in_ready} !== 4'b1011) begin
            n_err++;
            $display("FAIL %s done cycle: done,busy,ser_out,in_ready got %b expected 1011",
                     name, {done, busy, ser_out, in_ready});
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_valid8 = 1'b0; in_data8 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({in_ready, ser_out, busy, done} !== 4'b0100) begin
            n_err++;
            $display("FAIL reset_state: in_ready,ser_out,busy,done got %b expected 0100",
                     {in_ready, ser_out, busy, done});
        end
        n_cmp++;
        if ({in_ready8, ser_out8, busy8, done8} !== 4'b0100) begin
            n_err++;
            $display("FAIL reset_state8: got %b expected 0100", {in_ready8, ser_out8, busy8, done8});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, in_ready8} !== 2'b11) begin
            n_err++;
            $display("FAIL reset_release in_ready: got %b expected 11", {in_ready, in_ready8});
        end
    endtask

    task automatic test_basic;
        start_frame(41'h0A5);
        check_frame(41'h0A5, 1'b0, "basic_0A5");
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL basic done_one_cycle: got %b expected 0", done);
        end
    endtask

    task automatic test_patterns;
        start_frame(41'h1FF_FFFF_FFFF);
        check_frame(41'h1FF_FFFF_FFFF, 1'b1, "all_ones");
        start_frame(41'h0);
        check_frame(41'h0, 1'b0, "all_zero");
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 41'h001;
        @(posedge clk); #1;
        in_data  = 41'h002;
        check_frame(41'h001, 1'b1, "b2b_first");
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_frame(41'h002, 1'b1, "b2b_second");
    endtask

    task automatic test_ignore;
        int bad;
        start_frame(41'h0C3);
        fork
            check_frame(41'h0C3, 1'b0, "ignore_frame");
            begin
                repeat (49) @(posedge clk);
                #1;
                in_valid = 1'b1;
                in_data  = 41'h155;
                @(negedge clk);
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL ignore in_ready_busy: got %b expected 0", in_ready);
                end
                @(posedge clk); #1;
                in_valid = 1'b0;
                in_data  = '0;
            end
        join
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if ({ser_out, busy, done} !== 3'b100) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL ignore no_second_frame: %0d non-idle cycles, expected 0", bad);
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        start_frame(41'h0A5);
        repeat (59) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid in_ready_in_reset: got %b expected 0", in_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ser_out, busy, done, in_ready} !== 4'b1001) begin
            n_err++;
            $display("FAIL reset_mid after: ser_out,busy,done,in_ready got %b expected 1001",
                     {ser_out, busy, done, in_ready});
        end
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if ({ser_out, busy, done} !== 3'b100) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL reset_mid quiet: %0d non-idle cycles, expected 0", bad);
        end
        start_frame(41'h0A5);
        check_frame(41'h0A5, 1'b0, "after_reset");
    endtask

    task automatic test_bc1;
        logic [10:0] e;
        int bad;
        e = 11'b01000000101;
        bad = 0;
        @(posedge clk); #1;
        in_valid8 = 1'b1;
        in_data8  = 8'h81;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (ser_out8 !== e[11-k] || busy8 !== 1'b1 || done8 !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL bc1 frame: %0d bad cycles, expected 0 (seq 01000000101)", bad);
        end
        @(negedge clk);
        n_cmp++;
        if ({done8, busy8, ser_out8} !== 3'b101) begin
            n_err++;
            $display("FAIL bc1 done_at_t+12: done,busy,ser_out got %b expected 101",
                     {done8, busy8, ser_out8});
        end
        @(negedge clk);
        n_cmp++;
        if (done8 !== 1'b0) begin
            n_err++;
            $display("FAIL bc1 done_one_cycle: got %b expected 0", done8);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        test_bc1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
